sap_sequencer: RTL and testbench

//  Hardwired fetch/execute sequencer for the 8-bit SAP-1 datapath; drop-in replacement for the ROM microcode decoder.

---
 rtl/sap_pkg.sv | 51 +++++
 rtl/sap_decode.sv | 75 +++++++
 rtl/sap_sequencer.sv | 95 +++++++++
 tb/tb_sap_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared encodings for the SAP-1 hardwired sequencer: opcodes, control-word bit positions, FSM states.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package sap_pkg;

  localparam int OPC_W_DEF  = 4;
  localparam int CW_W_DEF   = 16;
  localparam int T_LAST_DEF = 5;

  // Opcodes (instr[7:4]); anything not listed decodes as NOP
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit positions
  localparam int CW_OI   = 15;
  localparam int CW_SU   = 14;
  localparam int CW_DONE = 13;
  localparam int CW_CE   = 11;
  localparam int CW_AI   = 10;
  localparam int CW_AO   = 9;
  localparam int CW_BI   = 8;
  localparam int CW_J    = 7;
  localparam int CW_CO   = 6;
  localparam int CW_II   = 5;
  localparam int CW_IO   = 4;
  localparam int CW_RI   = 3;
  localparam int CW_RO   = 2;
  localparam int CW_MI   = 1;
  localparam int CW_EO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // One-hot control-word bit
  function automatic logic [15:0] cw(input int idx);
    cw = 16'b1 << idx;
  endfunction

endpackage

// File: rtl/sap_decode.sv
// Combinational micro-step decode: (t_state, opcode, flags) -> raw control word and last-step marker.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the sequencer gates the result in stalled cycles. Macro: SAP_SEQ_SKIP_IDLE_EN.
module sap_decode
  import sap_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int CW_W   = CW_W_DEF,
  parameter int T_LAST = T_LAST_DEF
) (
  input  logic [2:0]       t_state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_zero,
  input  logic             flag_carry,
  output logic [CW_W-1:0]  ctrl_raw,
  output logic             last_step
);

  logic [3:0]  op;
  logic [15:0] cw_v;

  assign op = 4'(opcode);

  // Fetch is opcode-independent; execute steps decode the opcode from T2 onward
  always_comb begin
    cw_v = '0;
    case (t_state)
      3'd0: cw_v = cw(CW_MI) | cw(CW_CO);
      3'd1: cw_v = cw(CW_RO) | cw(CW_II) | cw(CW_CE);
      default: begin
        case (op)
          OP_LDA: begin
            if (t_state == 3'd2) cw_v = cw(CW_IO) | cw(CW_MI);
            if (t_state == 3'd3) cw_v = cw(CW_RO) | cw(CW_AI);
          end
          OP_ADD, OP_SUB: begin
            if (t_state == 3'd2) cw_v = cw(CW_IO) | cw(CW_MI);
            if (t_state == 3'd3) cw_v = cw(CW_RO) | cw(CW_BI);
            if (t_state == 3'd4) cw_v = cw(CW_EO) | cw(CW_AI) | ((op == OP_SUB) ? cw(CW_SU) : 16'h0);
          end
          OP_STA: begin
            if (t_state == 3'd2) cw_v = cw(CW_IO) | cw(CW_MI);
            if (t_state == 3'd3) cw_v = cw(CW_AO) | cw(CW_RI);
          end
          OP_LDI: if (t_state == 3'd2) cw_v = cw(CW_IO) | cw(CW_AI);
          OP_JMP: if (t_state == 3'd2) cw_v = cw(CW_IO) | cw(CW_J);
          OP_JC:  if (t_state == 3'd2 && flag_carry) cw_v = cw(CW_IO) | cw(CW_J);
          OP_JZ:  if (t_state == 3'd2 && flag_zero)  cw_v = cw(CW_IO) | cw(CW_J);
          OP_OUT: if (t_state == 3'd2) cw_v = cw(CW_AO) | cw(CW_OI);
          default: cw_v = '0;  // HLT and NOPs drive nothing
        endcase
      end
    endcase
  end

`ifdef SAP_SEQ_SKIP_IDLE_EN
  logic [2:0] fin;

  // Final execute step per opcode; HLT never completes a frame, it leaves RUN
  always_comb begin
    fin = 3'd2;
    case (op)
      OP_LDA, OP_STA: fin = 3'd3;
      OP_ADD, OP_SUB: fin = 3'd4;
      default:        fin = 3'd2;
    endcase
    last_step = ((t_state == fin) && (op != OP_HLT)) || (t_state == 3'(T_LAST));
  end
`else
  assign last_step = (t_state == 3'(T_LAST));
`endif

  assign ctrl_raw = CW_W'(cw_v | (last_step ? cw(CW_DONE) : 16'h0));

endmodule

// File: rtl/sap_sequencer.sv
// Hardwired SAP-1 fetch/execute sequencer: IDLE/RUN/HALT FSM, T-state counter, single-step handshake.
// Latency: ctrl is combinational from current state; t_state advances one step per accepted cycle.
// Backpressure: in step_mode the counter stalls until step_req; ctrl is zeroed while stalled. Macro: SAP_SEQ_SKIP_IDLE_EN.
module sap_sequencer
  import sap_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int CW_W   = CW_W_DEF,
  parameter int T_LAST = T_LAST_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             step_ack,
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_zero,
  input  logic             flag_carry,
  output logic [CW_W-1:0]  ctrl,
  output logic [2:0]       t_state,
  output logic             halted,
  output logic             busy
);

  // reset_n is expected to be released synchronously to clk by an upstream reset synchronizer
  state_e          state_q, state_d;
  logic [2:0]      t_q, t_d;
  logic [CW_W-1:0] ctrl_raw;
  logic            last_step;
  logic            adv;

  sap_decode #(
    .OPC_W (OPC_W),
    .CW_W  (CW_W),
    .T_LAST(T_LAST)
  ) u_decode (
    .t_state   (t_q),
    .opcode    (opcode),
    .flag_zero (flag_zero),
    .flag_carry(flag_carry),
    .ctrl_raw  (ctrl_raw),
    .last_step (last_step)
  );

  // Next state, T-counter advance, step handshake and control-word gating
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    adv      = 1'b0;
    step_ack = 1'b0;
    ctrl     = '0;
    case (state_q)
      ST_IDLE: begin
        t_d = 3'd0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        adv      = !step_mode || step_req;
        step_ack = step_mode && step_req;
        if (adv) begin
          ctrl = ctrl_raw;
          if (t_q == 3'd2 && 4'(opcode) == OP_HLT) begin
            state_d = ST_HALT;
          end else if (last_step) begin
            t_d = 3'd0;
          end else begin
            t_d = t_q + 3'd1;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d = ST_IDLE;
        t_d     = 3'd0;
      end
    endcase
  end

  // State and T-counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      t_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  assign t_state = t_q;
  assign busy    = (state_q == ST_RUN);
  assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer; inputs driven just after the falling edge, outputs sampled 1 time unit later.
// Latency: n/a.
// Backpressure: n/a. Macro: SAP_SEQ_SKIP_IDLE_EN selects the short-frame expectations.
module tb_sap_sequencer;

`ifdef SAP_SEQ_SKIP_IDLE_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step_req = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        flag_zero = 1'b0;
  logic        flag_carry = 1'b0;
  logic        step_ack;
  logic [15:0] ctrl;
  logic [2:0]  t_state;
  logic        halted;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Opcode table: opcode, zero flag, expected T2/T3/T4 control words (no done bit), final step
  logic [3:0]  tab_op [9] = '{4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h8, 4'hE, 4'h9};
  logic        tab_fz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] tab_c2 [9] = '{16'h0012, 16'h0012, 16'h0012, 16'h0410, 16'h0090, 16'h0000, 16'h0090, 16'h8200, 16'h0000};
  logic [15:0] tab_c3 [9] = '{16'h0404, 16'h0104, 16'h0208, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] tab_c4 [9] = '{16'h0000, 16'h4401, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  int          tab_fin[9] = '{3, 4, 3, 2, 2, 2, 2, 2, 2};

  sap_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .step_mode (step_mode),
    .step_req  (step_req),
    .step_ack  (step_ack),
    .opcode    (opcode),
    .flag_zero (flag_zero),
    .flag_carry(flag_carry),
    .ctrl      (ctrl),
    .t_state   (t_state),
    .halted    (halted),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic sync_to_t1();
    for (int i = 0; i < 10 && t_state !== 3'd1; i++) step_cycle();
    checks++;
    if (t_state !== 3'd1) begin errors++; $display("FAIL sync_to_t1: t_state %0d, wanted 1 within 10 cycles", t_state); end
  endtask

  task automatic test_reset();
    #1;
    reset_n = 1'b0;
    start   = 1'b1;
    opcode  = 4'h2;
    #1;
    checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h want 0000", ctrl); end
    checks++; if (t_state !== 3'd0) begin errors++; $display("FAIL reset_t: got %0d want 0", t_state); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (step_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", step_ack); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (ctrl !== 16'h0000 || busy !== 1'b0) begin errors++; $display("FAIL idle_to_run: ctrl %h busy %b want 0000 0", ctrl, busy); end
    step_cycle();
    checks++; if (t_state !== 3'd0 || ctrl !== 16'h0042 || busy !== 1'b1) begin errors++; $display("FAIL fetch_t0: t %0d ctrl %h busy %b want 0 0042 1", t_state, ctrl, busy); end
    step_cycle();
    checks++; if (t_state !== 3'd1 || ctrl !== 16'h0824) begin errors++; $display("FAIL fetch_t1: t %0d ctrl %h want 1 0824", t_state, ctrl); end
  endtask

  task automatic test_add();
    logic [2:0]  et [6];
    logic [15:0] ec [6];
    int n;
    start = 1'b0;
    if (SKIP) begin
      n = 5;
      et[0] = 3'd2; ec[0] = 16'h0012;
      et[1] = 3'd3; ec[1] = 16'h0104;
      et[2] = 3'd4; ec[2] = 16'h2401;
      et[3] = 3'd0; ec[3] = 16'h0042;
      et[4] = 3'd1; ec[4] = 16'h0824;
    end else begin
      n = 6;
      et[0] = 3'd2; ec[0] = 16'h0012;
      et[1] = 3'd3; ec[1] = 16'h0104;
      et[2] = 3'd4; ec[2] = 16'h0401;
      et[3] = 3'd5; ec[3] = 16'h2000;
      et[4] = 3'd0; ec[4] = 16'h0042;
      et[5] = 3'd1; ec[5] = 16'h0824;
    end
    for (int i = 0; i < n; i++) begin
      step_cycle();
      checks++;
      if (t_state !== et[i] || ctrl !== ec[i]) begin
        errors++; $display("FAIL add_step%0d: t %0d ctrl %h want %0d %h", i, t_state, ctrl, et[i], ec[i]);
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_low_ignored: busy %b want 1", busy); end
  endtask

  task automatic test_jc();
    sync_to_t1();
    opcode = 4'h7;
    flag_carry = 1'b0;
    step_cycle();
    checks++;
    if (t_state !== 3'd2 || ctrl !== (SKIP ? 16'h2000 : 16'h0000)) begin
      errors++; $display("FAIL jc_untaken: t %0d ctrl %h want 2 %h", t_state, ctrl, SKIP ? 16'h2000 : 16'h0000);
    end
    step_cycle();
    flag_carry = 1'b1;
    #1;
    checks++;
    if (ctrl !== (SKIP ? 16'h0042 : 16'h0000)) begin
      errors++; $display("FAIL jc_flag_outside_t2: ctrl %h want %h", ctrl, SKIP ? 16'h0042 : 16'h0000);
    end
    sync_to_t1();
    step_cycle();
    checks++;
    if (t_state !== 3'd2 || ctrl !== (SKIP ? 16'h2090 : 16'h0090)) begin
      errors++; $display("FAIL jc_taken: t %0d ctrl %h want 2 %h", t_state, ctrl, SKIP ? 16'h2090 : 16'h0090);
    end
  endtask

  task automatic test_opcodes();
    logic [15:0] exp_c;
    for (int k = 0; k < 9; k++) begin
      sync_to_t1();
      opcode = tab_op[k];
      flag_zero = tab_fz[k];
      flag_carry = 1'b0;
      step_cycle();
      exp_c = tab_c2[k] | ((SKIP && tab_fin[k] == 2) ? 16'h2000 : 16'h0000);
      checks++;
      if (t_state !== 3'd2 || ctrl !== exp_c) begin
        errors++; $display("FAIL op%h_t2: t %0d ctrl %h want 2 %h", tab_op[k], t_state, ctrl, exp_c);
      end
      if (tab_fin[k] >= 3) begin
        step_cycle();
        exp_c = tab_c3[k] | ((SKIP && tab_fin[k] == 3) ? 16'h2000 : 16'h0000);
        checks++;
        if (t_state !== 3'd3 || ctrl !== exp_c) begin
          errors++; $display("FAIL op%h_t3: t %0d ctrl %h want 3 %h", tab_op[k], t_state, ctrl, exp_c);
        end
      end
      if (tab_fin[k] >= 4) begin
        step_cycle();
        exp_c = tab_c4[k] | (SKIP ? 16'h2000 : 16'h0000);
        checks++;
        if (t_state !== 3'd4 || ctrl !== exp_c) begin
          errors++; $display("FAIL op%h_t4: t %0d ctrl %h want 4 %h", tab_op[k], t_state, ctrl, exp_c);
        end
      end
    end
    flag_zero = 1'b0;
  endtask

  task automatic test_halt();
    sync_to_t1();
    opcode = 4'hF;
    step_cycle();
    checks++; if (t_state !== 3'd2 || ctrl !== 16'h0000 || busy !== 1'b1) begin errors++; $display("FAIL hlt_t2: t %0d ctrl %h busy %b want 2 0000 1", t_state, ctrl, busy); end
    step_cycle();
    checks++; if (halted !== 1'b1 || busy !== 1'b0 || ctrl !== 16'h0000) begin errors++; $display("FAIL halt_enter: halted %b busy %b ctrl %h want 1 0 0000", halted, busy, ctrl); end
    for (int i = 0; i < 3; i++) begin
      start = ~start;
      step_req = ~step_req;
      step_mode = i[0];
      step_cycle();
      checks++;
      if (halted !== 1'b1 || step_ack !== 1'b0 || ctrl !== 16'h0000) begin
        errors++; $display("FAIL halt_hold%0d: halted %b ack %b ctrl %h want 1 0 0000", i, halted, step_ack, ctrl);
      end
    end
    start = 1'b0; step_req = 1'b0; step_mode = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || busy !== 1'b0 || t_state !== 3'd0) begin errors++; $display("FAIL halt_reset: halted %b busy %b t %0d want 0 0 0", halted, busy, t_state); end
    @(negedge clk);
    reset_n = 1'b1;
    step_cycle();
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL idle_hold: busy %b halted %b want 0 0", busy, halted); end
  endtask

  task automatic test_step();
    step_mode = 1'b1;
    step_req  = 1'b0;
    start     = 1'b1;
    opcode    = 4'h1;
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      checks++;
      if (busy !== 1'b1 || t_state !== 3'd0 || ctrl !== 16'h0000 || step_ack !== 1'b0) begin
        errors++; $display("FAIL step_stall%0d: busy %b t %0d ctrl %h ack %b want 1 0 0000 0", i, busy, t_state, ctrl, step_ack);
      end
    end
    step_req = 1'b1;
    #1;
    checks++; if (step_ack !== 1'b1 || ctrl !== 16'h0042) begin errors++; $display("FAIL step_accept: ack %b ctrl %h want 1 0042", step_ack, ctrl); end
    @(negedge clk);
    step_req = 1'b0;
    #1;
    checks++; if (t_state !== 3'd1 || step_ack !== 1'b0 || ctrl !== 16'h0000) begin errors++; $display("FAIL step_advance: t %0d ack %b ctrl %h want 1 0 0000", t_state, step_ack, ctrl); end
  endtask

  task automatic test_reset_mid();
    step_mode = 1'b0;
    step_cycle();
    checks++; if (t_state !== 3'd2 || ctrl !== 16'h0012) begin errors++; $display("FAIL lda_t2: t %0d ctrl %h want 2 0012", t_state, ctrl); end
    step_cycle();
    checks++; if (t_state !== 3'd3 || ctrl !== (SKIP ? 16'h2404 : 16'h0404)) begin errors++; $display("FAIL lda_t3: t %0d ctrl %h want 3 %h", t_state, ctrl, SKIP ? 16'h2404 : 16'h0404); end
    reset_n = 1'b0;
    #1;
    checks++; if (ctrl !== 16'h0000 || t_state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset: ctrl %h t %0d busy %b want 0000 0 0", ctrl, t_state, busy); end
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1;
    #1;
    checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL restart_idle: ctrl %h want 0000", ctrl); end
    step_cycle();
    checks++; if (t_state !== 3'd0 || ctrl !== 16'h0042) begin errors++; $display("FAIL restart_t0: t %0d ctrl %h want 0 0042", t_state, ctrl); end
    step_cycle();
    checks++; if (t_state !== 3'd1 || ctrl !== 16'h0824) begin errors++; $display("FAIL restart_t1: t %0d ctrl %h want 1 0824", t_state, ctrl); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_jc();
    test_opcodes();
    test_halt();
    test_step();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
